// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-path types: I-type funct3 encodings and the
// state/mode types used by the iterative immediate-shift sequencer.
package riscv_pkg;

  typedef enum logic [2:0] {
    F_ADDI  = 3'b000,
    F_SLLI  = 3'b001,
    F_SLTI  = 3'b010,
    F_SLTIU = 3'b011,
    F_XORI  = 3'b100,
    F_SRXI  = 3'b101,
    F_ORI   = 3'b110,
    F_ANDI  = 3'b111
  } i_func_t;

  localparam logic [2:0] F3_SLLI = F_SLLI;
  localparam logic [2:0] F3_SRXI = F_SRXI;

  // Remaining-count width holds 0..31 with headroom; k width holds 0..8.
  localparam int CNT_W = 6;
  localparam int K_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  typedef enum logic [1:0] {
    SH_LL  = 2'd0,
    SH_RL  = 2'd1,
    SH_RA  = 2'd2,
    SH_ILL = 2'd3
  } shift_mode_t;

  // SRLI/SRAI share funct3; instruction bit 30 picks the arithmetic form.
  function automatic shift_mode_t decode_mode(input logic [2:0] funct3, input logic arith);
    shift_mode_t m;
    m = SH_ILL;
    if (funct3 == F3_SLLI)
      m = SH_LL;
    else if (funct3 == F3_SRXI)
      m = arith ? SH_RA : SH_RL;
    return m;
  endfunction

endpackage

// File: rtl/i_shift_sequencer_step.sv
// One iteration of the narrow shifter: shifts the accumulator by k bits
// (0..STEP) in the direction and fill mode selected by mode.
import riscv_pkg::*;

module i_shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [1:0]      mode,
  input  logic [K_W-1:0]  k,
  output logic [XLEN-1:0] shifted
);

  // Illegal mode passes the accumulator through untouched.
  always_comb begin
    shifted = acc;
    case (mode)
      SH_LL:   shifted = acc << k;
      SH_RL:   shifted = acc >> k;
      SH_RA:   shifted = XLEN'($signed(acc) >>> k);
      default: shifted = acc;
    endcase
  end

endmodule

// File: rtl/i_shift_sequencer.sv
// Multi-cycle SLLI/SRLI/SRAI sequencer: accepts an operand bundle, walks
// the shift through i_shift_step STEP bits per cycle, then holds the
// result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a new op, start_ready = 1
// SHIFT | iterating, k = min(STEP, remaining) bits per cycle
// DONE  | result_valid = 1, waiting for result_ready
import riscv_pkg::*;

module i_shift_sequencer #(
  parameter int STEP = 1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic            arith,
  input  logic [XLEN-1:0] rs1,
  input  logic [4:0]      shamt,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            op_err,
  output logic            busy
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  shift_state_t     state_q, state_d;
  shift_mode_t      mode_q, mode_d, mode_in;
  logic [XLEN-1:0]  acc_q, acc_d, step_out;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [K_W-1:0]   k;

  assign mode_in = decode_mode(funct3, arith);

  // Last iteration takes only what is left so the count lands exactly on 0.
  assign k = (rem_q < STEP_C) ? rem_q[K_W-1:0] : STEP_C[K_W-1:0];

  i_shift_step #(.XLEN(XLEN)) u_step (
    .acc     (acc_q),
    .mode    (mode_q),
    .k       (k),
    .shifted (step_out)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SH_LL;
      acc_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          acc_d  = rs1;
          rem_d  = {1'b0, shamt};
          mode_d = mode_in;
          err_d  = (mode_in == SH_ILL);
          if (mode_in == SH_ILL || shamt == 5'd0)
            state_d = DONE;
          else
            state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = step_out;
        rem_d = rem_q - {{(CNT_W-K_W){1'b0}}, k};
        if (rem_d == '0)
          state_d = DONE;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    start_ready  = (state_q == IDLE);
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
    result       = acc_q;
    op_err       = err_q;
  end

endmodule

// File: tb/tb_i_shift_sequencer.sv
// Bench for i_shift_sequencer: two instances (STEP = 1 and STEP = 8) share
// stimulus; expected results/latencies go into per-instance queues when an
// op is driven and are popped when each instance raises result_valid.
module tb_i_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, arith, result_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [4:0]  shamt;

  logic        start_ready1, result_valid1, op_err1, busy1;
  logic [31:0] result1;
  logic        start_ready8, result_valid8, op_err8, busy8;
  logic [31:0] result8;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        ar;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  i_shift_sequencer #(.STEP(1), .XLEN(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready1),
    .funct3(funct3), .arith(arith), .rs1(rs1), .shamt(shamt),
    .result_valid(result_valid1), .result_ready(result_ready), .result(result1),
    .op_err(op_err1), .busy(busy1)
  );

  i_shift_sequencer #(.STEP(8), .XLEN(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready8),
    .funct3(funct3), .arith(arith), .rs1(rs1), .shamt(shamt),
    .result_valid(result_valid8), .result_ready(result_ready), .result(result8),
    .op_err(op_err8), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] f3, input logic [4:0] sh, input int s);
    if ((f3 != 3'b001 && f3 != 3'b101) || sh == 5'd0) return 1;
    return (int'(sh) + s - 1) / s + 1;
  endfunction

  function automatic logic [31:0] ref_shift(input logic [2:0] f3, input logic ar,
                                            input logic [31:0] a, input logic [4:0] sh);
    if (f3 == 3'b001) return a << sh;
    if (f3 == 3'b101 && ar) return 32'($signed(a) >>> sh);
    if (f3 == 3'b101) return a >> sh;
    return a;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid1"}, {31'd0, result_valid1}, 32'd0);
    check({tag, "_ready1"}, {31'd0, start_ready1}, 32'd1);
    check({tag, "_err1"},   {31'd0, op_err1}, 32'd0);
    check({tag, "_busy1"},  {31'd0, busy1}, 32'd0);
    check({tag, "_valid8"}, {31'd0, result_valid8}, 32'd0);
    check({tag, "_ready8"}, {31'd0, start_ready8}, 32'd1);
  endtask

  // Called just after a falling edge with both instances idle.
  task automatic run_op(input logic [2:0] f3, input logic ar, input logic [31:0] a,
                        input logic [4:0] sh, input logic [31:0] er, input logic ee,
                        input int hold);
    exp_t e;
    int   cyc;
    bit   d1, d8;
    funct3 = f3; arith = ar; rs1 = a; shamt = sh; start_valid = 1'b1;
    e.res = er; e.err = ee;
    e.lat = lat_of(f3, sh, 1); q1.push_back(e);
    e.lat = lat_of(f3, sh, 8); q8.push_back(e);
    @(negedge clk);
    cyc = 1;
    start_valid = 1'b0;
    rs1 = $urandom; shamt = 5'($urandom); funct3 = 3'($urandom); arith = 1'($urandom);
    d1 = 1'b0; d8 = 1'b0;
    while (!(d1 && d8) && cyc <= 40) begin
      if (!d1 && result_valid1) begin
        e = q1.pop_front();
        check("latency1", 32'(cyc), 32'(e.lat));
        check("result1", result1, e.res);
        check("op_err1", {31'd0, op_err1}, {31'd0, e.err});
        d1 = 1'b1;
      end
      if (!d8 && result_valid8) begin
        e = q8.pop_front();
        check("latency8", 32'(cyc), 32'(e.lat));
        check("result8", result8, e.res);
        check("op_err8", {31'd0, op_err8}, {31'd0, e.err});
        d8 = 1'b1;
      end
      if (!(d1 && d8)) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!d1) begin check("timeout1", 32'd0, 32'd1); q1.delete(); end
    if (!d8) begin check("timeout8", 32'd0, 32'd1); q8.delete(); end
    for (int h = 0; h < hold; h++) begin
      start_valid = h[0];
      rs1 = $urandom; shamt = 5'($urandom); funct3 = 3'b001;
      @(negedge clk);
      check("hold_result1", result1, er);
      check("hold_valid1", {31'd0, result_valid1}, 32'd1);
      check("hold_sready1", {31'd0, start_ready1}, 32'd0);
      check("hold_result8", result8, er);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check_idle("after_pop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b101, 1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
    vecs[1] = '{3'b101, 1'b0, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
    vecs[2] = '{3'b101, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{3'b001, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4] = '{3'b101, 1'b0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    vecs[5] = '{3'b000, 1'b0, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{3'b111, 1'b1, 32'hCAFE_F00D, 5'd3,  32'hCAFE_F00D, 1'b1};
    vecs[7] = '{3'b101, 1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
    vecs[8] = '{3'b001, 1'b1, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500, 1'b0};
    vecs[9] = '{3'b101, 1'b0, 32'hFFFF_FFFF, 5'd9,  32'h007F_FFFF, 1'b0};

    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    funct3 = 3'b000; arith = 1'b0; rs1 = '0; shamt = '0;
    #1;
    check("reset_result1", result1, 32'd0);
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].f3, vecs[i].ar, vecs[i].a, vecs[i].sh, vecs[i].res, vecs[i].err, 0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  f3;
      logic        ar;
      logic [31:0] a;
      logic [4:0]  sh;
      f3 = (i % 3 == 0) ? 3'b001 : 3'b101;
      ar = 1'($urandom);
      a  = $urandom;
      sh = 5'($urandom);
      run_op(f3, ar, a, sh, ref_shift(f3, ar, a, sh), 1'b0, 0);
    end

    // Consumer stalls 10 cycles in DONE while start_valid pulses are ignored,
    // then a new op goes in right after the release.
    run_op(3'b101, 1'b0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 10);
    run_op(3'b001, 1'b0, 32'h0000_00F0, 5'd4, 32'h0000_0F00, 1'b0, 0);

    // Reset three cycles into a long shift.
    funct3 = 3'b101; arith = 1'b0; rs1 = 32'hFFFF_FFFF; shamt = 5'd20; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    check("midshift_busy1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_result1", result1, 32'd0);
    check("abort_result8", result8, 32'd0);
    check_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b001, 1'b0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
